load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of WAIT cycles without mem_done before a timeout fault; legal range 1..255.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline presents a load/store.
REQ-005 req_ready  out  1  unit accepts a request on this cycle.
REQ-006 is_load  in  1  1 = load, 0 = store.
REQ-007 funct3  in  3  RV32I LOAD/STORE funct3.
REQ-008 base  in  32  rs1 value.
REQ-009 imm  in  32  sign-extended offset.
REQ-010 store_data  in  32  rs2 value.
REQ-011 rd  in  5  load destination register.
REQ-012 mem_start, mem_write_enable  out  1 each  to memory controller.
REQ-013 mem_address  out  32;  mem_mode  out  3;  mem_write_data  out  32  to memory controller.
REQ-014 mem_done, mem_active  in  1 each;  mem_read_data  in  32  from memory controller.
REQ-015 wb_valid  out  1;  wb_rd  out  5;  wb_data  out  32  register write-back.
REQ-016 op_done  out  1  one-cycle pulse on successful completion of any operation.
REQ-017 fault  out  1  one-cycle pulse;  fault_cause  out  2  (01 misaligned, 10 illegal funct3, 11 timeout);  fault_addr  out  32.

Function
REQ-018 The FSM SHALL have states IDLE, START, WAIT, FINISH.
REQ-019 req_ready SHALL be 1 only in IDLE with mem_active = 0.
REQ-020 On an edge with req_valid && req_ready, the unit SHALL latch is_load, funct3, rd, store_data and ea = base + imm (mod 2^32).
REQ-021 The latched request SHALL be checked the same edge: legal load funct3 = 000, 001, 010, 100, 101; legal store funct3 = 000, 001, 010; any other value SHALL produce an illegal-funct3 fault.
REQ-022 A misaligned fault SHALL be produced for halfword access with ea[0] = 1 and for word access with ea[1:0] != 0; illegal funct3 takes priority over misalignment.
REQ-023 A fault SHALL pulse fault for one cycle with fault_cause and fault_addr = ea, issue no mem_start, and keep the FSM in IDLE.
REQ-024 A legal request SHALL go to START; mem_start SHALL be 1 for exactly that one cycle; the next state SHALL be WAIT.
REQ-025 mem_address = ea, mem_mode = funct3, mem_write_data = store_data and mem_write_enable = !is_load SHALL be held stable from START through the cycle mem_done is sampled.
REQ-026 Outside START/WAIT, mem_write_enable SHALL be 0 and mem_address/mem_mode/mem_write_data SHALL be 0.
REQ-027 In WAIT, a sampled mem_done = 1 SHALL capture mem_read_data into wb_data and go to FINISH.
REQ-028 FINISH SHALL last one cycle: op_done = 1; wb_valid = 1 only for a load with rd != 0; wb_rd = latched rd; then IDLE.
REQ-029 Minimum latency from the accepting edge to op_done SHALL be START (1) + WAIT (≥1) + FINISH (1) cycles.
REQ-030 An 8-bit WAIT counter SHALL clear on entering WAIT and increment each WAIT cycle without mem_done.
REQ-031 When the counter reaches TIMEOUT, the unit SHALL pulse fault with cause 11 and fault_addr = ea, and return to IDLE with no op_done.
REQ-032 req_valid SHALL be ignored outside IDLE; mem_done outside WAIT SHALL be ignored.
REQ-033 wb_valid, op_done and fault SHALL never be high in the same cycle.

Reset
REQ-034 On reset, regardless of state, the FSM SHALL enter IDLE and all outputs SHALL be 0, including wb_data, wb_rd, fault_addr and fault_cause.
REQ-035 After reset release, req_ready SHALL stay 0 until mem_active = 0, so that an aborted controller operation drains first.

Verification
REQ-036 LW: base 0x100, imm 0x4, mem_done after 4 cycles with read data 0xDEADBEEF, rd 5 -> mem_start one cycle, mem_address 0x104, mem_mode 010, wb_valid with wb_rd 5, wb_data 0xDEADBEEF, op_done.
REQ-037 SH: ea 0x202, store_data 0x1234 -> mem_write_enable 1 from START to mem_done, then 0; op_done 1; wb_valid 0.
REQ-038 LH with ea 0x203 -> fault cause 01, fault_addr 0x203, no mem_start; store with funct3 100 -> fault cause 10.
REQ-039 TIMEOUT = 16, mem_done never asserted -> fault cause 11 exactly 16 WAIT cycles after START; mem_write_enable 0 afterwards.
REQ-040 Reset asserted in WAIT while mem_active = 1 -> all outputs 0 immediately; req_ready 0 until mem_active falls; then LB of 0x80, rd 0, completes with op_done and no wb_valid.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Handshake and bus bundle between pipeline, load/store unit,
// memory controller and register write-back.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] imm;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_start;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [2:0]  mem_mode;
  logic [31:0] mem_write_data;
  logic        mem_done;
  logic        mem_active;
  logic [31:0] mem_read_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_done;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  modport slave (
    input  req_valid, is_load, funct3, base, imm,
    input  store_data, rd,
    input  mem_done, mem_active, mem_read_data,
    output req_ready,
    output mem_start, mem_write_enable, mem_address,
    output mem_mode, mem_write_data,
    output wb_valid, wb_rd, wb_data, op_done,
    output fault, fault_cause, fault_addr
  );

  modport master (
    output req_valid, is_load, funct3, base, imm,
    output store_data, rd,
    output mem_done, mem_active, mem_read_data,
    input  req_ready,
    input  mem_start, mem_write_enable, mem_address,
    input  mem_mode, mem_write_data,
    input  wb_valid, wb_rd, wb_data, op_done,
    input  fault, fault_cause, fault_addr
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: address generation, legality checks,
// memory controller sequencing with timeout, and write-back.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    FINISH
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        lat_load;
  logic [2:0]  lat_f3;
  logic [4:0]  lat_rd;
  logic [31:0] lat_sd;
  logic [31:0] lat_ea;
  logic [7:0]  cnt;
  logic [31:0] ea;
  logic        ready;
  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        timeout;
  logic        fault_q;
  logic [1:0]  cause_q;
  logic [31:0] fault_addr_q;
  logic [31:0] wb_data_q;

  assign ea      = bus.base + bus.imm;
  // Wait for the controller to drain before taking new work
  assign ready   = (state == IDLE) && !reset && !bus.mem_active;
  assign accept  = bus.req_valid && ready;
  assign timeout = (state == WAIT) && !bus.mem_done
                && (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    if (bus.is_load)
      illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010,
                                     3'b100, 3'b101});
    else
      illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
    misaligned = ((bus.funct3[1:0] == 2'b01) && ea[0])
              || ((bus.funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx             = state;
    bus.mem_start        = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_address      = '0;
    bus.mem_mode         = '0;
    bus.mem_write_data   = '0;
    bus.wb_valid         = 1'b0;
    bus.wb_rd            = '0;
    bus.op_done          = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && !illegal && !misaligned)
          state_nx = START;
      end
      START: begin
        bus.mem_start        = 1'b1;
        bus.mem_write_enable = !lat_load;
        bus.mem_address      = lat_ea;
        bus.mem_mode         = lat_f3;
        bus.mem_write_data   = lat_sd;
        state_nx             = WAIT;
      end
      WAIT: begin
        bus.mem_write_enable = !lat_load;
        bus.mem_address      = lat_ea;
        bus.mem_mode         = lat_f3;
        bus.mem_write_data   = lat_sd;
        if (bus.mem_done)  state_nx = FINISH;
        else if (timeout)  state_nx = IDLE;
      end
      FINISH: begin
        bus.op_done  = 1'b1;
        bus.wb_valid = lat_load && (lat_rd != 5'd0);
        bus.wb_rd    = lat_rd;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_load     <= 1'b0;
      lat_f3       <= '0;
      lat_rd       <= '0;
      lat_sd       <= '0;
      lat_ea       <= '0;
      cnt          <= '0;
      fault_q      <= 1'b0;
      cause_q      <= '0;
      fault_addr_q <= '0;
      wb_data_q    <= '0;
    end else begin
      fault_q <= 1'b0;
      if (accept) begin
        lat_load <= bus.is_load;
        lat_f3   <= bus.funct3;
        lat_rd   <= bus.rd;
        lat_sd   <= bus.store_data;
        lat_ea   <= ea;
        if (illegal || misaligned) begin
          fault_q      <= 1'b1;
          cause_q      <= illegal ? 2'b10 : 2'b01;
          fault_addr_q <= ea;
        end
      end
      if (state == START)
        cnt <= '0;
      else if ((state == WAIT) && !bus.mem_done)
        cnt <= cnt + 8'd1;
      if ((state == WAIT) && bus.mem_done)
        wb_data_q <= bus.mem_read_data;
      if (timeout) begin
        fault_q      <= 1'b1;
        cause_q      <= 2'b11;
        fault_addr_q <= lat_ea;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;
  assign bus.fault_addr  = fault_addr_q;
  assign bus.wb_data     = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Covers loads, stores, faults, timeout and reset abort.
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic ld, input logic [2:0] f3,
                     input logic [31:0] b, input logic [31:0] i,
                     input logic [31:0] sd, input logic [4:0] r);
    bus.req_valid  = 1'b1;
    bus.is_load    = ld;
    bus.funct3     = f3;
    bus.base       = b;
    bus.imm        = i;
    bus.store_data = sd;
    bus.rd         = r;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req_valid     = 1'b0;
    bus.is_load       = 1'b0;
    bus.funct3        = '0;
    bus.base          = '0;
    bus.imm           = '0;
    bus.store_data    = '0;
    bus.rd            = '0;
    bus.mem_done      = 1'b0;
    bus.mem_active    = 1'b0;
    bus.mem_read_data = '0;

    tick;
    tick;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_start", bus.mem_start, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_wbdata", bus.wb_data, 0);
    chk("rst_faddr", bus.fault_addr, 0);
    reset = 1'b0;
    #1;
    chk("idle_ready", bus.req_ready, 1);

    // LW 0x104, done after 4 WAIT cycles
    req(1'b1, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5);
    tick;
    bus.req_valid  = 1'b0;
    bus.mem_active = 1'b1;
    chk("lw_start", bus.mem_start, 1);
    chk("lw_addr", bus.mem_address, 32'h104);
    chk("lw_mode", bus.mem_mode, 3'b010);
    chk("lw_we", bus.mem_write_enable, 0);
    chk("lw_ready_busy", bus.req_ready, 0);
    tick;
    chk("lw_start_once", bus.mem_start, 0);
    chk("lw_addr_wait", bus.mem_address, 32'h104);
    tick;
    tick;
    tick;
    bus.mem_done      = 1'b1;
    bus.mem_read_data = 32'hDEADBEEF;
    tick;
    bus.mem_done   = 1'b0;
    bus.mem_active = 1'b0;
    chk("lw_opdone", bus.op_done, 1);
    chk("lw_wbvalid", bus.wb_valid, 1);
    chk("lw_wbrd", bus.wb_rd, 5);
    chk("lw_wbdata", bus.wb_data, 32'hDEADBEEF);
    chk("lw_fault", bus.fault, 0);
    chk("lw_addr_fin", bus.mem_address, 0);
    tick;
    chk("lw_opdone_end", bus.op_done, 0);
    chk("lw_wbvalid_end", bus.wb_valid, 0);

    // mem_done in IDLE is ignored
    bus.mem_done = 1'b1;
    tick;
    bus.mem_done = 1'b0;
    chk("stray_done", bus.op_done, 0);
    chk("stray_start", bus.mem_start, 0);

    // SH 0x202; req_valid held during START must be ignored
    req(1'b0, 3'b001, 32'h200, 32'h2, 32'h1234, 5'd7);
    tick;
    bus.base = 32'h900;
    chk("sh_start", bus.mem_start, 1);
    chk("sh_addr", bus.mem_address, 32'h202);
    chk("sh_we_start", bus.mem_write_enable, 1);
    chk("sh_wdata", bus.mem_write_data, 32'h1234);
    tick;
    bus.req_valid     = 1'b0;
    chk("sh_addr_ign", bus.mem_address, 32'h202);
    chk("sh_we_wait", bus.mem_write_enable, 1);
    bus.mem_done      = 1'b1;
    bus.mem_read_data = 32'h0BADF00D;
    tick;
    bus.mem_done = 1'b0;
    chk("sh_opdone", bus.op_done, 1);
    chk("sh_wbvalid", bus.wb_valid, 0);
    chk("sh_we_fin", bus.mem_write_enable, 0);
    tick;
    chk("sh_idle", bus.op_done, 0);

    // LH at 0x203: misaligned
    req(1'b1, 3'b001, 32'h200, 32'h3, 32'h0, 5'd3);
    tick;
    bus.req_valid = 1'b0;
    chk("lh_fault", bus.fault, 1);
    chk("lh_cause", bus.fault_cause, 2'b01);
    chk("lh_faddr", bus.fault_addr, 32'h203);
    chk("lh_nostart", bus.mem_start, 0);
    tick;
    chk("lh_pulse", bus.fault, 0);
    chk("lh_nostart2", bus.mem_start, 0);

    // Store funct3 100: illegal
    req(1'b0, 3'b100, 32'h300, 32'h0, 32'h0, 5'd0);
    tick;
    bus.req_valid = 1'b0;
    chk("sfn_fault", bus.fault, 1);
    chk("sfn_cause", bus.fault_cause, 2'b10);
    chk("sfn_faddr", bus.fault_addr, 32'h300);
    chk("sfn_nostart", bus.mem_start, 0);
    tick;

    // Illegal beats misaligned: load funct3 011 at 0x1
    req(1'b1, 3'b011, 32'h0, 32'h1, 32'h0, 5'd1);
    tick;
    bus.req_valid = 1'b0;
    chk("prio_cause", bus.fault_cause, 2'b10);
    chk("prio_faddr", bus.fault_addr, 32'h1);
    tick;

    // SW with negative offset, mem_done never comes
    req(1'b0, 3'b010, 32'h10, 32'hFFFFFFF4, 32'hCAFEF00D, 5'd0);
    tick;
    bus.req_valid  = 1'b0;
    bus.mem_active = 1'b1;
    chk("to_start", bus.mem_start, 1);
    chk("to_addr", bus.mem_address, 32'h4);
    tick;
    for (int i = 0; i < 16; i++) begin
      chk("to_nofault", bus.fault, 0);
      chk("to_we_wait", bus.mem_write_enable, 1);
      tick;
    end
    chk("to_fault", bus.fault, 1);
    chk("to_cause", bus.fault_cause, 2'b11);
    chk("to_faddr", bus.fault_addr, 32'h4);
    chk("to_we_after", bus.mem_write_enable, 0);
    chk("to_opdone", bus.op_done, 0);
    tick;
    chk("to_pulse", bus.fault, 0);
    bus.mem_active = 1'b0;
    #1;

    // Reset while WAIT with controller busy
    req(1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 5'd9);
    tick;
    bus.req_valid  = 1'b0;
    bus.mem_active = 1'b1;
    tick;
    chk("rw_addr_wait", bus.mem_address, 32'h40);
    reset = 1'b1;
    #1;
    chk("rw_addr", bus.mem_address, 0);
    chk("rw_cause", bus.fault_cause, 0);
    chk("rw_faddr", bus.fault_addr, 0);
    chk("rw_wbdata", bus.wb_data, 0);
    chk("rw_ready", bus.req_ready, 0);
    tick;
    reset = 1'b0;
    tick;
    chk("rw_drain", bus.req_ready, 0);
    bus.mem_active = 1'b0;
    #1;
    chk("rw_ready_up", bus.req_ready, 1);

    // LB of 0x80 into x0
    req(1'b1, 3'b000, 32'h80, 32'h0, 32'h0, 5'd0);
    tick;
    bus.req_valid  = 1'b0;
    bus.mem_active = 1'b1;
    chk("lb_start", bus.mem_start, 1);
    chk("lb_addr", bus.mem_address, 32'h80);
    chk("lb_mode", bus.mem_mode, 3'b000);
    tick;
    bus.mem_done      = 1'b1;
    bus.mem_read_data = 32'h55;
    tick;
    bus.mem_done   = 1'b0;
    bus.mem_active = 1'b0;
    chk("lb_opdone", bus.op_done, 1);
    chk("lb_wbvalid", bus.wb_valid, 0);
    chk("lb_wbrd", bus.wb_rd, 0);
    tick;
    chk("lb_idle", bus.op_done, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
